// File: rtl/cpm_reg_arb_if.sv
// Bundle of requester-side handshake and register-side control signals for cpm_reg_arb.
// The arbiter takes the slave view; requesters and the shared register see the master view.
interface cpm_reg_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 8
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    ReqVld;
  logic [NUM_REQ-1:0]    ReqClr;
  logic [NUM_REQ*DW-1:0] ReqDat;
  logic                  ClrAll;
  logic [NUM_REQ-1:0]    ReqRdy;
  logic                  RegClear;
  logic [DW-1:0]         RegDataClr;
  logic                  RegEnable;
  logic [DW-1:0]         RegDataIn;
  logic [IW-1:0]         GrantIdx;
  logic                  Busy;

  modport master (
    output ReqVld, ReqClr, ReqDat, ClrAll,
    input  ReqRdy, RegClear, RegDataClr, RegEnable, RegDataIn, GrantIdx, Busy
  );

  modport slave (
    input  ReqVld, ReqClr, ReqDat, ClrAll,
    output ReqRdy, RegClear, RegDataClr, RegEnable, RegDataIn, GrantIdx, Busy
  );
endinterface

// File: rtl/cpm_reg_arb.sv
// Round-robin write arbiter for a shared CPM_REG_RCE-style register, with a pre-emptive global clear.
// Every output is a flop loaded on the edge that enters the cycle in which it is active.
module cpm_reg_arb #(
  parameter int unsigned   NUM_REQ = 4,
  parameter int unsigned   DW      = 8,
  parameter logic [DW-1:0] CLR_DAT = '0
) (
  input logic           Clk,
  input logic           Rstn,
  cpm_reg_arb_if.slave  bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GCLR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic               clr_q, clr_d;
  logic               en_q, en_d;
  logic [DW-1:0]      din_q, din_d;
  logic               busy_q, busy_d;

  logic               any_req;
  logic [IW-1:0]      winner;
  int unsigned        idx;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!any_req && bus.ReqVld[idx[IW-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[IW-1:0];
      end
    end
  end

  // Outputs are computed together with the next state so they are registered
  // and line up exactly with the ISSUE/GCLR cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    rdy_d   = '0;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (bus.ClrAll) begin
          state_d = GCLR;
          clr_d   = 1'b1;
        end else if (any_req) begin
          state_d       = ISSUE;
          grant_d       = winner;
          ptr_d         = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IW'(1);
          rdy_d[winner] = 1'b1;
          if (bus.ReqClr[winner]) begin
            clr_d = 1'b1;
          end else begin
            en_d  = 1'b1;
            din_d = bus.ReqDat[32'(winner)*DW +: DW];
          end
        end
      end
      ISSUE: begin
        if (bus.ClrAll) begin
          state_d = GCLR;
          clr_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GCLR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      rdy_q   <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rdy_q   <= rdy_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ReqRdy     = rdy_q;
  assign bus.RegClear   = clr_q;
  assign bus.RegDataClr = CLR_DAT;
  assign bus.RegEnable  = en_q;
  assign bus.RegDataIn  = din_q;
  assign bus.GrantIdx   = grant_q;
  assign bus.Busy       = busy_q;
endmodule

// File: tb/tb_cpm_reg_arb.sv
// Self-checking bench for cpm_reg_arb: directed cycle table, async-reset sequence,
// then randomized requesters checked against a behavioural arbitration model.
module tb_cpm_reg_arb;
  localparam int unsigned   NUM_REQ = 4;
  localparam int unsigned   DW      = 8;
  localparam logic [DW-1:0] CLR_DAT = 8'h3C;
  localparam logic [31:0]   TBL_DAT = 32'h44A5_2211;

  logic Clk;
  logic Rstn;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  cpm_reg_arb_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

  cpm_reg_arb #(.NUM_REQ(NUM_REQ), .DW(DW), .CLR_DAT(CLR_DAT)) dut (
    .Clk  (Clk),
    .Rstn (Rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] rdy, input logic rc,
                          input logic en, input logic [7:0] din, input logic [1:0] gi,
                          input logic busy);
    chk({tag, " ReqRdy"},     32'(bus.ReqRdy),     32'(rdy));
    chk({tag, " RegClear"},   32'(bus.RegClear),   32'(rc));
    chk({tag, " RegEnable"},  32'(bus.RegEnable),  32'(en));
    chk({tag, " RegDataIn"},  32'(bus.RegDataIn),  32'(din));
    chk({tag, " GrantIdx"},   32'(bus.GrantIdx),   32'(gi));
    chk({tag, " Busy"},       32'(bus.Busy),       32'(busy));
    chk({tag, " RegDataClr"}, 32'(bus.RegDataClr), 32'(CLR_DAT));
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [3:0] clr;
    logic       ca;
    logic [3:0] rdy;
    logic       rc;
    logic       en;
    logic [7:0] din;
    logic [1:0] gi;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] vld, input logic [3:0] clr, input logic ca,
                     input logic [3:0] rdy, input logic rc, input logic en,
                     input logic [7:0] din, input logic [1:0] gi, input logic busy);
    vec_t v;
    v.vld = vld; v.clr = clr; v.ca = ca;
    v.rdy = rdy; v.rc = rc; v.en = en; v.din = din; v.gi = gi; v.busy = busy;
    tbl.push_back(v);
  endtask

  // Behavioural model: kind of op occupying the current cycle (0 none, 1 issue, 2 global clear).
  int         m_ptr;
  int         m_kind;
  logic [3:0] e_rdy;
  logic       e_rc;
  logic       e_en;
  logic [7:0] e_din;
  logic [1:0] e_gi;

  task automatic model_reset();
    m_ptr = 0; m_kind = 0;
    e_rdy = '0; e_rc = 1'b0; e_en = 1'b0; e_din = '0; e_gi = '0;
  endtask

  task automatic model_edge(input logic [3:0] vld, input logic [3:0] clr,
                            input logic [31:0] dat, input logic ca);
    int nk = 0;
    int w  = -1;
    if (m_kind == 0) begin
      if (ca) nk = 2;
      else begin
        for (int k = 0; k < 4; k++) begin
          int j = (m_ptr + k) % 4;
          if (w < 0 && vld[j]) w = j;
        end
        if (w >= 0) nk = 1;
      end
    end else if (m_kind == 1 && ca) begin
      nk = 2;
    end
    e_rdy = '0; e_rc = 1'b0; e_en = 1'b0;
    if (nk == 1) begin
      e_rdy[w] = 1'b1;
      e_gi     = 2'(w);
      m_ptr    = (w + 1) % 4;
      if (clr[w]) e_rc = 1'b1;
      else begin
        e_en  = 1'b1;
        e_din = dat[w*8 +: 8];
      end
    end else if (nk == 2) begin
      e_rc = 1'b1;
    end
    m_kind = nk;
  endtask

  logic [3:0]  pend;
  logic [3:0]  clr_r;
  logic [31:0] dat_r;
  logic        ca_r;

  initial begin
    Rstn = 1'b0;
    bus.ReqVld = '0; bus.ReqClr = '0; bus.ReqDat = TBL_DAT; bus.ClrAll = 1'b0;

    //  vld     clr     ca    rdy     rc    en    din    gi  busy
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    add(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 8'hA5, 2, 1'b1); // single write req2
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 2, 1'b0);
    add(4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 8'h44, 3, 1'b1); // wrap: 3 then 0
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h44, 3, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h11, 0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 0, 1'b0);
    add(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h11, 1, 1'b1); // requester clear
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 1, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h11, 1, 1'b1); // global clear pre-empts
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 1, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h11, 0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 0, 1'b0);
    add(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 8'h44, 3, 1'b1); // bring ptr back to 0
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h44, 3, 1'b0);
    add(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h11, 0, 1'b1); // round robin 0..3
    add(4'b1110, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 0, 1'b0);
    add(4'b1110, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 8'h22, 1, 1'b1);
    add(4'b1100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h22, 1, 1'b0);
    add(4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 8'hA5, 2, 1'b1);
    add(4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 2, 1'b0);
    add(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 8'h44, 3, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h44, 3, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h44, 3, 1'b1); // ClrAll held: GCLR/IDLE
    add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h44, 3, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h44, 3, 1'b1);
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h44, 3, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h11, 0, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h11, 0, 1'b1); // ISSUE -> GCLR
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 0, 1'b0);

    repeat (2) @(negedge Clk);
    chk_outs("reset", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    Rstn = 1'b1;

    foreach (tbl[n]) begin
      bus.ReqVld = tbl[n].vld;
      bus.ReqClr = tbl[n].clr;
      bus.ClrAll = tbl[n].ca;
      @(posedge Clk); #1;
      chk_outs($sformatf("vec%0d", n), tbl[n].rdy, tbl[n].rc, tbl[n].en,
               tbl[n].din, tbl[n].gi, tbl[n].busy);
    end

    // Asynchronous reset in the middle of an ISSUE cycle, then pointer restart.
    bus.ReqVld = 4'b0100; bus.ReqClr = '0; bus.ClrAll = 1'b0;
    @(posedge Clk); #1;
    chk_outs("pre_rst", 4'b0100, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b1);
    Rstn = 1'b0;
    bus.ReqVld = '0;
    #1;
    chk_outs("mid_rst", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge Clk); @(negedge Clk);
    Rstn = 1'b1;
    bus.ReqVld = 4'b1111;
    @(posedge Clk); #1;
    chk_outs("post_rst", 4'b0001, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1);
    bus.ReqVld = '0;
    @(posedge Clk); #1;
    chk_outs("post_rst_idle", 4'b0000, 1'b0, 1'b0, 8'h11, 2'd0, 1'b0);

    // Randomized requesters against the behavioural model.
    Rstn = 1'b0;
    model_reset();
    pend = '0; clr_r = '0; dat_r = '0; ca_r = 1'b0;
    bus.ReqVld = '0; bus.ReqClr = '0; bus.ReqDat = '0; bus.ClrAll = 1'b0;
    @(negedge Clk); @(negedge Clk);
    Rstn = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]        = 1'b1;
          clr_r[i]       = ($urandom_range(0, 3) == 0);
          dat_r[i*8 +: 8] = 8'($urandom);
        end
      end
      ca_r = ($urandom_range(0, 9) == 0);
      bus.ReqVld = pend;
      bus.ReqClr = clr_r;
      bus.ReqDat = dat_r;
      bus.ClrAll = ca_r;
      @(posedge Clk);
      model_edge(pend, clr_r, dat_r, ca_r);
      #1;
      chk_outs($sformatf("rnd%0d", cyc), e_rdy, e_rc, e_en, e_din, e_gi, (m_kind != 0));
      // Acked requester drops; its data bus is scrambled to prove the latched value is used.
      for (int i = 0; i < 4; i++) begin
        if (e_rdy[i]) begin
          pend[i]         = 1'b0;
          dat_r[i*8 +: 8] = 8'($urandom);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
